regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined core; replaces the single-write, fixed-width register file.
- Adds NUM_RD read ports and two prioritised write-back ports with same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard for hazard detection, a multi-cycle clear sequencer, and an indexed debug read port.
- Sits between decode (reads, alloc) and write-back (writes).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; NREG = 2**ADDR_W registers; register 0 is hard-wired to zero.
- NUM_RD, 2, number of read ports (1..4).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_rs_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- o_rs_data  out  NUM_RD*DATA_W  read data, packed the same way.
- o_rs_busy  out  NUM_RD  scoreboard busy flag per read port.
- i_wr_en  in  2  write enables; bit 1 is the higher-priority port.
- i_wr_addr  in  2*ADDR_W  write addresses.
- i_wr_data  in  2*DATA_W  write data.
- i_alloc_en  in  1  marks the destination register busy (instruction issued).
- i_alloc_addr  in  ADDR_W  destination register to mark busy.
- i_clr_req  in  1  single-cycle pulse requesting zeroing of the whole file.
- o_clr_busy  out  1  clear sequence in progress.
- o_clr_done  out  1  one-cycle pulse when the clear sequence completes.
- i_dbg_addr  in  ADDR_W  debug read index.
- o_dbg_data  out  DATA_W  debug read data; no bypass applied.

Behaviour:
- Reset (asynchronous, i_rst=1):
  - All registers 0; all busy bits 0; FSM to IDLE.
  - o_clr_busy=0, o_clr_done=0.
  - o_rs_data and o_dbg_data read 0 through the combinational path.
  - Reset asserted mid-clear aborts the sequence immediately; no o_clr_done pulse is produced.
- Reads:
  - Combinational, zero latency.
  - Address 0 always returns 0 with busy=0.
  - Bypass: if a write to the same nonzero address is enabled in the current cycle, return that write data (port 1 over port 0); otherwise return the stored value.
- Writes:
  - Registered on the rising edge; writes to address 0 are dropped.
  - Both ports writing the same address: port 1 data is stored.
- Scoreboard:
  - A write to address a clears busy[a] at the edge.
  - i_alloc_en sets busy[i_alloc_addr] at the edge; alloc to address 0 is ignored.
  - Alloc and write to the same address in the same cycle: alloc wins, busy=1.
  - o_rs_busy[k] = busy[addr_k] AND NOT (any enabled write to addr_k this cycle).
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE --i_clr_req--> CLEAR.
    - On entry, index := 1 and all busy bits are cleared.
  - CLEAR: each cycle, reg[index] := 0 and index increments.
    - When index = NREG-1 has been written, go to DONE.
    - The sequence takes NREG-1 cycles in CLEAR.
  - DONE: o_clr_done=1 for exactly one cycle, then IDLE.
  - o_clr_busy=1 in CLEAR and DONE.
  - While o_clr_busy=1:
    - External writes and allocs are ignored.
    - Reads return stored values without bypass.
    - o_rs_busy=0.
  - i_clr_req while o_clr_busy=1 is ignored.
- Index counter is ADDR_W bits and must not wrap past NREG-1.
- The debug port returns the stored value; address 0 returns 0.

Decomposition:
- Package regfile_pkg:
  - clr_state_e enum {IDLE, CLEAR, DONE}.
  - Default parameter constants.
  - Function bypass_sel that resolves port priority.
- Sub-module regfile_clr_seq holds the FSM, the index counter and the clear-busy strobe.
- Storage, bypass and scoreboard stay in the top module.

Test Plan:
- Reset and read: assert i_rst, write x5=0xDEADBEEF while reset is held, release reset -> x5 reads 0; o_rs_busy all 0; o_clr_busy=0.
- Bypass and priority: same cycle, port0 writes x3=0x11 and port1 writes x3=0x22; rs0 reads x3 -> 0x22 in that cycle; after the edge the stored value is 0x22; a write to x0 leaves x0 at 0.
- Scoreboard: alloc x7 -> next cycle o_rs_busy=1 for a reader of x7. Write x7=0x55 -> busy=0 in the write cycle, data=0x55. Alloc and write x7 in the same cycle -> busy=1 after the edge.
- Clear sequence: load x1..x31 with nonzero values, pulse i_clr_req.
  - o_clr_busy high for 32 cycles (31 CLEAR + 1 DONE).
  - o_clr_done pulses once.
  - All registers read 0 afterwards; writes attempted during the clear are lost.
- Reset mid-clear: assert i_rst at cycle 10 of CLEAR -> o_clr_busy drops asynchronously; no o_clr_done; all registers 0.
- Parameter sweep: DATA_W=64, ADDR_W=4, NUM_RD=3 -> clear takes 15 CLEAR cycles; a 64-bit value 0x0123456789ABCDEF round-trips on all 3 read ports.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
//   clr_state_e : states of the whole-file clear sequencer
//   Def*        : default parameter values
//   bypass_sel  : resolves write-port priority for read bypass
package regfile_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;
  localparam int unsigned DefNumRd = 2;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_e;

  // One-hot {use_port1, use_port0}; port 1 wins when both ports hit.
  function automatic logic [1:0] bypass_sel(input logic hit0, input logic hit1);
    return {hit1, hit0 & ~hit1};
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: zeroes registers 1..NREG-1, one per cycle, then pulses done.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   clr_req_i      : start request (ignored while busy)
//   clr_busy_o     : high in CLEAR and DONE
//   clr_done_o     : one-cycle pulse in DONE
//   busy_clr_o     : strobe on the entry edge; clears the whole scoreboard
//   clr_we_o       : zero-write enable for register clr_idx_o
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_req_i,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic              busy_clr_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_idx_o
);

  localparam logic [ADDR_W-1:0] LastIdx = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] OneIdx  = {{(ADDR_W-1){1'b0}}, 1'b1};

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_busy_o = 1'b0;
    clr_done_o = 1'b0;
    busy_clr_o = 1'b0;
    clr_we_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d    = CLEAR;
          idx_d      = OneIdx;
          busy_clr_o = 1'b1;
        end
      end
      CLEAR: begin
        clr_busy_o = 1'b1;
        clr_we_o   = 1'b1;
        // Hold the index at the last register instead of wrapping to 0.
        if (idx_q == LastIdx) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + OneIdx;
        end
      end
      DONE: begin
        clr_busy_o = 1'b1;
        clr_done_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_idx_o = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write bypass, busy scoreboard,
// whole-file clear sequencer and a debug read port. Register 0 reads as zero.
//   i_rs_addr/o_rs_data/o_rs_busy : NUM_RD combinational read ports (packed)
//   i_wr_en/i_wr_addr/i_wr_data   : two write ports, port 1 has priority
//   i_alloc_en/i_alloc_addr       : mark a destination register busy
//   i_clr_req/o_clr_busy/o_clr_done : clear sequence control/status
//   i_dbg_addr/o_dbg_data         : stored-value debug read, no bypass
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned NUM_RD = DefNumRd
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_RD*ADDR_W-1:0] i_rs_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rs_data,
  output logic [NUM_RD-1:0]        o_rs_busy,
  input  logic [1:0]               i_wr_en,
  input  logic [2*ADDR_W-1:0]      i_wr_addr,
  input  logic [2*DATA_W-1:0]      i_wr_data,
  input  logic                     i_alloc_en,
  input  logic [ADDR_W-1:0]        i_alloc_addr,
  input  logic                     i_clr_req,
  output logic                     o_clr_busy,
  output logic                     o_clr_done,
  input  logic [ADDR_W-1:0]        i_dbg_addr,
  output logic [DATA_W-1:0]        o_dbg_data
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d;

  logic [ADDR_W-1:0] wa [2];
  logic [DATA_W-1:0] wd [2];

  logic              clr_busy, busy_clr, clr_we;
  logic [ADDR_W-1:0] clr_idx;

  assign wa[0] = i_wr_addr[0 +: ADDR_W];
  assign wa[1] = i_wr_addr[ADDR_W +: ADDR_W];
  assign wd[0] = i_wr_data[0 +: DATA_W];
  assign wd[1] = i_wr_data[DATA_W +: DATA_W];

  regfile_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .clr_req_i  (i_clr_req),
    .clr_busy_o (clr_busy),
    .clr_done_o (o_clr_done),
    .busy_clr_o (busy_clr),
    .clr_we_o   (clr_we),
    .clr_idx_o  (clr_idx)
  );

  assign o_clr_busy = clr_busy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      busy_q <= busy_d;
    end
  end

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (clr_we) regs_d[clr_idx] = '0;
    if (!clr_busy) begin
      // Port 1 is applied last so it wins a same-address collision.
      for (int p = 0; p < 2; p++) begin
        if (i_wr_en[p] && (wa[p] != '0)) begin
          regs_d[wa[p]] = wd[p];
          busy_d[wa[p]] = 1'b0;
        end
      end
      // Alloc after writes: a new producer keeps the register busy.
      if (i_alloc_en && (i_alloc_addr != '0)) busy_d[i_alloc_addr] = 1'b1;
    end
    if (busy_clr) busy_d = '0;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // Bypass is suppressed during reset and while the clear sequence runs.
  logic byp_ok;
  assign byp_ok = ~clr_busy & ~i_rst;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0, hit1;
    logic [1:0]        sel;
    logic [DATA_W-1:0] data;

    assign ra   = i_rs_addr[k*ADDR_W +: ADDR_W];
    assign hit0 = byp_ok & i_wr_en[0] & (wa[0] == ra);
    assign hit1 = byp_ok & i_wr_en[1] & (wa[1] == ra);
    assign sel  = bypass_sel(hit0, hit1);

    always_comb begin
      if (i_rst || (ra == '0)) begin
        data = '0;
      end else if (sel[1]) begin
        data = wd[1];
      end else if (sel[0]) begin
        data = wd[0];
      end else begin
        data = regs_q[ra];
      end
    end

    assign o_rs_data[k*DATA_W +: DATA_W] = data;
    assign o_rs_busy[k] = ~i_rst & ~clr_busy & (ra != '0) & busy_q[ra] & ~(hit0 | hit1);
  end

  assign o_dbg_data = i_rst ? '0 : regs_q[i_dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NR   = 2;
  localparam int unsigned NREG = 32;
  localparam int unsigned BDW  = 64;
  localparam int unsigned BAW  = 4;
  localparam int unsigned BNR  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic [NR*AW-1:0] rs_addr;
  logic [NR*DW-1:0] rs_data;
  logic [NR-1:0]    rs_busy;
  logic [1:0]       wr_en;
  logic [2*AW-1:0]  wr_addr;
  logic [2*DW-1:0]  wr_data;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic             clr_req, clr_busy, clr_done;
  logic [AW-1:0]    dbg_addr;
  logic [DW-1:0]    dbg_data;

  // Swept-parameter instance
  logic [BNR*BAW-1:0] b_rs_addr;
  logic [BNR*BDW-1:0] b_rs_data;
  logic [BNR-1:0]     b_rs_busy;
  logic [1:0]         b_wr_en;
  logic [2*BAW-1:0]   b_wr_addr;
  logic [2*BDW-1:0]   b_wr_data;
  logic               b_alloc_en;
  logic [BAW-1:0]     b_alloc_addr;
  logic               b_clr_req, b_clr_busy, b_clr_done;
  logic [BAW-1:0]     b_dbg_addr;
  logic [BDW-1:0]     b_dbg_data;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural register contents and busy flags.
  logic [DW-1:0] mem    [NREG];
  logic          busy_m [NREG];

  regfile_mp u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rs_addr    (rs_addr),
    .o_rs_data    (rs_data),
    .o_rs_busy    (rs_busy),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_alloc_en   (alloc_en),
    .i_alloc_addr (alloc_addr),
    .i_clr_req    (clr_req),
    .o_clr_busy   (clr_busy),
    .o_clr_done   (clr_done),
    .i_dbg_addr   (dbg_addr),
    .o_dbg_data   (dbg_data)
  );

  regfile_mp #(
    .DATA_W (BDW),
    .ADDR_W (BAW),
    .NUM_RD (BNR)
  ) u_dut_b (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rs_addr    (b_rs_addr),
    .o_rs_data    (b_rs_data),
    .o_rs_busy    (b_rs_busy),
    .i_wr_en      (b_wr_en),
    .i_wr_addr    (b_wr_addr),
    .i_wr_data    (b_wr_data),
    .i_alloc_en   (b_alloc_en),
    .i_alloc_addr (b_alloc_addr),
    .i_clr_req    (b_clr_req),
    .o_clr_busy   (b_clr_busy),
    .o_clr_done   (b_clr_done),
    .i_dbg_addr   (b_dbg_addr),
    .o_dbg_data   (b_dbg_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    wr_en    = 2'b00;
    alloc_en = 1'b0;
    clr_req  = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      mem[i]    = '0;
      busy_m[i] = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] rdd(input int k);
    return rs_data[k*DW +: DW];
  endfunction

  function automatic logic [BDW-1:0] b_rdd(input int k);
    return b_rs_data[k*BDW +: BDW];
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 2) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 7));
  endfunction

  // Expected read value given the inputs currently driven.
  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == '0) return '0;
    if (wr_en[1] && wr_addr[AW +: AW] == a) return wr_data[DW +: DW];
    if (wr_en[0] && wr_addr[0 +: AW] == a) return wr_data[0 +: DW];
    return mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == '0) return 1'b0;
    if (wr_en[1] && wr_addr[AW +: AW] == a) return 1'b0;
    if (wr_en[0] && wr_addr[0 +: AW] == a) return 1'b0;
    return busy_m[a];
  endfunction

  // Apply the current cycle's writes and alloc to the model (call before tick).
  task automatic commit();
    logic [AW-1:0] a;
    for (int p = 0; p < 2; p++) begin
      a = wr_addr[p*AW +: AW];
      if (wr_en[p] && a != '0) begin
        mem[a]    = wr_data[p*DW +: DW];
        busy_m[a] = 1'b0;
      end
    end
    if (alloc_en && alloc_addr != '0) busy_m[alloc_addr] = 1'b1;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    wr_en      = 2'b01;
    wr_addr    = {5'd0, 5'd5};
    wr_data    = {32'h0, 32'hDEADBEEF};
    rs_addr    = {5'd0, 5'd5};
    dbg_addr   = 5'd5;
    tick();
    tick();
    #1;
    checks++;
    if (rdd(0) !== 32'h0) begin
      failures++;
      $display("FAIL reset_read_held: got %h exp %h", rdd(0), 32'h0);
    end
    idle_a();
    tick();
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rdd(0) !== 32'h0) begin
      failures++;
      $display("FAIL reset_x5: got %h exp %h", rdd(0), 32'h0);
    end
    checks++;
    if (rs_busy !== 2'b00) begin
      failures++;
      $display("FAIL reset_busy: got %b exp %b", rs_busy, 2'b00);
    end
    checks++;
    if ({clr_busy, clr_done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_clr_flags: got %b exp %b", {clr_busy, clr_done}, 2'b00);
    end
    checks++;
    if (dbg_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_dbg: got %h exp %h", dbg_data, 32'h0);
    end
    tick();
  endtask

  task automatic test_bypass();
    wr_en   = 2'b11;
    wr_addr = {5'd3, 5'd3};
    wr_data = {32'h22, 32'h11};
    rs_addr = {5'd0, 5'd3};
    #1;
    checks++;
    if (rdd(0) !== 32'h22) begin
      failures++;
      $display("FAIL bypass_prio: got %h exp %h", rdd(0), 32'h22);
    end
    checks++;
    if (rdd(1) !== 32'h0) begin
      failures++;
      $display("FAIL read_x0: got %h exp %h", rdd(1), 32'h0);
    end
    commit();
    tick();
    idle_a();
    dbg_addr = 5'd3;
    #1;
    checks++;
    if (rdd(0) !== 32'h22 || dbg_data !== 32'h22) begin
      failures++;
      $display("FAIL stored_prio: got %h/%h exp %h", rdd(0), dbg_data, 32'h22);
    end
    // Port 0 alone bypasses; port 1 targets x0 and must be dropped.
    wr_en   = 2'b11;
    wr_addr = {5'd0, 5'd4};
    wr_data = {32'hFFFF_FFFF, 32'h44};
    rs_addr = {5'd0, 5'd4};
    #1;
    checks++;
    if (rdd(0) !== 32'h44 || rdd(1) !== 32'h0) begin
      failures++;
      $display("FAIL bypass_p0_x0: got %h/%h exp %h/%h", rdd(0), rdd(1), 32'h44, 32'h0);
    end
    commit();
    tick();
    idle_a();
    dbg_addr = 5'd0;
    #1;
    checks++;
    if (dbg_data !== 32'h0 || rdd(1) !== 32'h0) begin
      failures++;
      $display("FAIL x0_write_dropped: got %h/%h exp 0", dbg_data, rdd(1));
    end
  endtask

  task automatic test_scoreboard();
    alloc_en   = 1'b1;
    alloc_addr = 5'd7;
    commit();
    tick();
    idle_a();
    rs_addr = {5'd7, 5'd7};
    #1;
    checks++;
    if (rs_busy !== 2'b11) begin
      failures++;
      $display("FAIL sb_alloc: got %b exp %b", rs_busy, 2'b11);
    end
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd7};
    wr_data = {32'h0, 32'h55};
    #1;
    checks++;
    if (rs_busy !== 2'b00 || rdd(0) !== 32'h55) begin
      failures++;
      $display("FAIL sb_write_cycle: got %b/%h exp 00/%h", rs_busy, rdd(0), 32'h55);
    end
    commit();
    tick();
    idle_a();
    #1;
    checks++;
    if (rs_busy !== 2'b00 || rdd(1) !== 32'h55) begin
      failures++;
      $display("FAIL sb_after_write: got %b/%h exp 00/%h", rs_busy, rdd(1), 32'h55);
    end
    alloc_en   = 1'b1;
    alloc_addr = 5'd7;
    wr_en      = 2'b10;
    wr_addr    = {5'd7, 5'd0};
    wr_data    = {32'h66, 32'h0};
    commit();
    tick();
    idle_a();
    #1;
    checks++;
    if (rs_busy !== 2'b11 || rdd(0) !== 32'h66) begin
      failures++;
      $display("FAIL sb_alloc_wins: got %b/%h exp 11/%h", rs_busy, rdd(0), 32'h66);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] ra;
    for (int n = 0; n < 400; n++) begin
      wr_en      = 2'($urandom);
      wr_addr    = {rand_addr(), rand_addr()};
      wr_data    = {$urandom, $urandom};
      alloc_en   = 1'($urandom);
      alloc_addr = rand_addr();
      rs_addr    = {rand_addr(), rand_addr()};
      dbg_addr   = AW'($urandom);
      #1;
      for (int k = 0; k < NR; k++) begin
        ra = rs_addr[k*AW +: AW];
        checks++;
        if (rdd(k) !== exp_data(ra)) begin
          failures++;
          $display("FAIL rand_data[%0d] x%0d: got %h exp %h", k, ra, rdd(k), exp_data(ra));
        end
        checks++;
        if (rs_busy[k] !== exp_busy(ra)) begin
          failures++;
          $display("FAIL rand_busy[%0d] x%0d: got %b exp %b", k, ra, rs_busy[k], exp_busy(ra));
        end
      end
      checks++;
      if (dbg_data !== mem[dbg_addr]) begin
        failures++;
        $display("FAIL rand_dbg x%0d: got %h exp %h", dbg_addr, dbg_data, mem[dbg_addr]);
      end
      commit();
      tick();
    end
    idle_a();
  endtask

  task automatic test_clear();
    logic [AW-1:0] ra;
    logic [DW-1:0] exp;
    int n_busy;
    int n_done;
    for (int a = 1; a < 32; a += 2) begin
      wr_en   = (a + 1 < 32) ? 2'b11 : 2'b01;
      wr_addr = {AW'(a + 1), AW'(a)};
      wr_data = {$urandom | 32'h1, $urandom | 32'h1};
      commit();
      tick();
    end
    idle_a();
    alloc_en   = 1'b1;
    alloc_addr = 5'd9;
    commit();
    tick();
    idle_a();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < NREG; i++) busy_m[i] = 1'b0;
    n_busy = 0;
    n_done = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      // Writes, allocs and a new request aimed at the read address: all must be ignored.
      ra         = AW'($urandom_range(1, 31));
      rs_addr    = {5'd9, ra};
      wr_en      = 2'b11;
      wr_addr    = {ra, ra};
      wr_data    = {32'hBAD0_0001, 32'hBAD0_0000};
      alloc_en   = 1'b1;
      alloc_addr = ra;
      clr_req    = 1'b1;
      #1;
      if (!clr_busy) break;
      n_busy++;
      if (clr_done) n_done++;
      // In CLEAR cycle cyc the index is cyc+1, so x1..x<cyc> are already zero.
      exp = (int'(ra) <= cyc) ? 32'h0 : mem[ra];
      checks++;
      if (rdd(0) !== exp || rs_busy !== 2'b00) begin
        failures++;
        $display("FAIL clear_mid cyc%0d x%0d: got %h/%b exp %h/00", cyc, ra, rdd(0), rs_busy,
                 exp);
      end
      tick();
    end
    idle_a();
    model_reset();
    checks++;
    if (n_busy != 32) begin
      failures++;
      $display("FAIL clear_busy_len: got %0d exp %0d", n_busy, 32);
    end
    checks++;
    if (n_done != 1) begin
      failures++;
      $display("FAIL clear_done_count: got %0d exp %0d", n_done, 1);
    end
    for (int a = 0; a < 32; a++) begin
      dbg_addr = AW'(a);
      rs_addr  = {AW'(a), AW'(a)};
      #1;
      checks++;
      if (dbg_data !== 32'h0 || rdd(1) !== 32'h0 || rs_busy !== 2'b00) begin
        failures++;
        $display("FAIL clear_after x%0d: got %h/%h/%b exp 0/0/00", a, dbg_data, rdd(1), rs_busy);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    int n_done;
    int n_busy;
    wr_en   = 2'b11;
    wr_addr = {5'd20, 5'd12};
    wr_data = {32'hDEF, 32'hABC};
    commit();
    tick();
    idle_a();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (9) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({clr_busy, clr_done} !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_clear_async: got %b exp %b", {clr_busy, clr_done}, 2'b00);
    end
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    n_done = 0;
    n_busy = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (clr_done) n_done++;
      if (clr_busy) n_busy++;
      tick();
    end
    checks++;
    if (n_done != 0 || n_busy != 0) begin
      failures++;
      $display("FAIL rst_mid_clear_resume: got done=%0d busy=%0d exp 0/0", n_done, n_busy);
    end
    dbg_addr = 5'd12;
    rs_addr  = {5'd20, 5'd12};
    #1;
    checks++;
    if (dbg_data !== 32'h0 || rdd(0) !== 32'h0 || rdd(1) !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_clear_regs: got %h/%h/%h exp 0", dbg_data, rdd(0), rdd(1));
    end
  endtask

  task automatic test_param_sweep();
    int n_busy;
    int n_done;
    b_wr_en   = 2'b10;
    b_wr_addr = {4'd9, 4'd0};
    b_wr_data = {64'h0123456789ABCDEF, 64'h0};
    b_rs_addr = {4'd9, 4'd9, 4'd9};
    #1;
    for (int k = 0; k < BNR; k++) begin
      checks++;
      if (b_rdd(k) !== 64'h0123456789ABCDEF) begin
        failures++;
        $display("FAIL sweep_bypass[%0d]: got %h exp %h", k, b_rdd(k), 64'h0123456789ABCDEF);
      end
    end
    tick();
    b_wr_en    = 2'b00;
    b_dbg_addr = 4'd9;
    #1;
    for (int k = 0; k < BNR; k++) begin
      checks++;
      if (b_rdd(k) !== 64'h0123456789ABCDEF) begin
        failures++;
        $display("FAIL sweep_stored[%0d]: got %h exp %h", k, b_rdd(k), 64'h0123456789ABCDEF);
      end
    end
    checks++;
    if (b_dbg_data !== 64'h0123456789ABCDEF) begin
      failures++;
      $display("FAIL sweep_dbg: got %h exp %h", b_dbg_data, 64'h0123456789ABCDEF);
    end
    b_clr_req = 1'b1;
    tick();
    b_clr_req = 1'b0;
    n_busy = 0;
    n_done = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      if (!b_clr_busy) break;
      n_busy++;
      if (b_clr_done) n_done++;
      tick();
    end
    checks++;
    if (n_busy != 16 || n_done != 1) begin
      failures++;
      $display("FAIL sweep_clear: got busy=%0d done=%0d exp 16/1", n_busy, n_done);
    end
    #1;
    checks++;
    if (b_rdd(2) !== 64'h0) begin
      failures++;
      $display("FAIL sweep_cleared: got %h exp %h", b_rdd(2), 64'h0);
    end
    tick();
  endtask

  initial begin
    rs_addr      = '0;
    wr_en        = '0;
    wr_addr      = '0;
    wr_data      = '0;
    alloc_en     = 1'b0;
    alloc_addr   = '0;
    clr_req      = 1'b0;
    dbg_addr     = '0;
    b_rs_addr    = '0;
    b_wr_en      = '0;
    b_wr_addr    = '0;
    b_wr_data    = '0;
    b_alloc_en   = 1'b0;
    b_alloc_addr = '0;
    b_clr_req    = 1'b0;
    b_dbg_addr   = '0;
    model_reset();

    test_reset();
    test_bypass();
    test_scoreboard();
    test_random();
    test_clear();
    test_reset_mid_clear();
    test_param_sweep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
